// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register: FSM states and default bus field widths.
package mdr_pkg;

  localparam int unsigned DefByteW = 8;
  localparam int unsigned DefOpcW  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStore
  } state_e;

endpackage

// File: rtl/mdr_serdes_if.sv
// Byte-wide memory bus between the MDR (master) and memory (slave).
interface mdr_serdes_if
  import mdr_pkg::*;
#(
  parameter int unsigned BYTE_W = DefByteW
);

  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_rready;
  logic [BYTE_W-1:0] mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;

  modport master (
    input  mem_rdata, mem_rvalid, mem_wready,
    output mem_rready, mem_wdata, mem_wvalid
  );

  modport slave (
    output mem_rdata, mem_rvalid, mem_wready,
    input  mem_rready, mem_wdata, mem_wvalid
  );

endinterface

// File: rtl/mdr_shifter.sv
// Word-wide shift register shared by the load and store paths; bytes enter and leave at the
// end selected by MSB_FIRST.
module mdr_shifter #(
  parameter int unsigned  BYTE_W    = 8,
  parameter int unsigned  NBYTES    = 2,
  parameter bit           MSB_FIRST = 1'b1,
  localparam int unsigned WORD_W    = BYTE_W * NBYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] out_byte_o,
  output logic [WORD_W-1:0] nxt_o
);

  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] shifted;

  // One shift serves both paths: loads shift a byte in, stores shift zeros behind the output byte.
  if (NBYTES == 1) begin : g_single
    assign shifted    = byte_i;
    assign out_byte_o = sr_q;
  end else if (MSB_FIRST) begin : g_msb
    assign shifted    = {sr_q[WORD_W-BYTE_W-1:0], byte_i};
    assign out_byte_o = sr_q[WORD_W-1 -: BYTE_W];
  end else begin : g_lsb
    assign shifted    = {byte_i, sr_q[WORD_W-1:BYTE_W]};
    assign out_byte_o = sr_q[BYTE_W-1:0];
  end

  assign nxt_o = shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_data_i;
    end else if (shift_i) begin
      sr_q <= shifted;
    end
  end

endmodule

// File: rtl/mdr_serdes.sv
// Memory data register: assembles bus bytes into a decoded load word and serialises store words
// back onto the byte bus, one transaction at a time.
module mdr_serdes
  import mdr_pkg::*;
#(
  parameter int unsigned  BYTE_W    = DefByteW,
  parameter int unsigned  NBYTES    = 2,
  parameter int unsigned  OPC_W     = DefOpcW,
  parameter int unsigned  ADDR_W    = 12,
  parameter bit           MSB_FIRST = 1'b1,
  localparam int unsigned WORD_W    = BYTE_W * NBYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              st_start,
  input  logic              abort,
  input  logic [WORD_W-1:0] st_data,
  mdr_serdes_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] word_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [OPC_W-1:0]  opc_o
);

  localparam int unsigned CntW = $clog2(NBYTES + 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WORD_W-1:0] word_q;
  logic              rready_q;
  logic              wvalid_q;
  logic              done_q;

  logic              rd_acc;
  logic              wr_acc;
  logic              last_beat;
  logic              sr_clr;
  logic              sr_load;
  logic              sr_shift;
  logic [BYTE_W-1:0] sr_byte;
  logic [WORD_W-1:0] sr_nxt;

  assign rd_acc    = bus.mem_rvalid && rready_q;
  assign wr_acc    = wvalid_q && bus.mem_wready;
  assign last_beat = (cnt_q == CntW'(NBYTES - 1));

  // Shifter controls are gated by abort so a cancelled beat never lands in the register.
  always_comb begin
    sr_clr   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_byte  = '0;
    if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (ld_start)      sr_clr  = 1'b1;
          else if (st_start) sr_load = 1'b1;
        end
        StLoad: begin
          sr_shift = rd_acc;
          sr_byte  = bus.mem_rdata;
        end
        StStore: sr_shift = wr_acc;
        default: ;
      endcase
    end
  end

  mdr_shifter #(
    .BYTE_W   (BYTE_W),
    .NBYTES   (NBYTES),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (sr_clr),
    .load_i     (sr_load),
    .load_data_i(st_data),
    .shift_i    (sr_shift),
    .byte_i     (sr_byte),
    .out_byte_o (bus.mem_wdata),
    .nxt_o      (sr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      word_q   <= '0;
      rready_q <= 1'b0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q  <= StIdle;
        rready_q <= 1'b0;
        wvalid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ld_start) begin
              state_q  <= StLoad;
              cnt_q    <= '0;
              rready_q <= 1'b1;
            end else if (st_start) begin
              state_q  <= StStore;
              cnt_q    <= '0;
              wvalid_q <= 1'b1;
            end
          end
          StLoad: begin
            if (rd_acc) begin
              cnt_q <= cnt_q + CntW'(1);
              if (last_beat) begin
                word_q   <= sr_nxt;
                rready_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= StIdle;
              end
            end
          end
          StStore: begin
            if (wr_acc) begin
              cnt_q <= cnt_q + CntW'(1);
              if (last_beat) begin
                wvalid_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.mem_rready = rready_q;
  assign bus.mem_wvalid = wvalid_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign word_o         = word_q;
  assign byte_o         = word_q[BYTE_W-1:0];
  assign addr_o         = word_q[ADDR_W-1:0];
  assign opc_o          = word_q[WORD_W-1 -: OPC_W];

endmodule

// File: tb/tb_mdr_serdes.sv
// Bench for mdr_serdes: MSB-first and LSB-first instances share stimulus; a negedge monitor
// checks done words and write beats against queues filled by a byte-order model.
module tb_mdr_serdes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_start = 1'b0;
  logic        st_start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] st_data = '0;
  logic [7:0]  rdata = '0;
  logic        rvalid = 1'b0;
  logic        wready = 1'b0;

  always #5 clk = ~clk;

  mdr_serdes_if #(.BYTE_W(8)) if_m ();
  mdr_serdes_if #(.BYTE_W(8)) if_l ();

  assign if_m.mem_rdata  = rdata;
  assign if_m.mem_rvalid = rvalid;
  assign if_m.mem_wready = wready;
  assign if_l.mem_rdata  = rdata;
  assign if_l.mem_rvalid = rvalid;
  assign if_l.mem_wready = wready;

  logic        busy_m, done_m, busy_l, done_l;
  logic [15:0] word_m, word_l;
  logic [7:0]  byte_m, byte_l;
  logic [11:0] addr_m, addr_l;
  logic [3:0]  opc_m, opc_l;

  mdr_serdes #(.MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .st_start(st_start), .abort(abort),
    .st_data(st_data), .bus(if_m), .busy(busy_m), .done(done_m), .word_o(word_m),
    .byte_o(byte_m), .addr_o(addr_m), .opc_o(opc_m)
  );

  mdr_serdes #(.MSB_FIRST(1'b0)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .st_start(st_start), .abort(abort),
    .st_data(st_data), .bus(if_l), .busy(busy_l), .done(done_l), .word_o(word_l),
    .byte_o(byte_l), .addr_o(addr_l), .opc_o(opc_l)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Scoreboard: expected word_o at each done pulse, and expected bytes per accepted write beat.
  logic [15:0] q_m[$];
  logic [15:0] q_l[$];
  logic [7:0]  qb_m[$];
  logic [7:0]  qb_l[$];
  logic [15:0] last_m = '0;
  logic [15:0] last_l = '0;
  bit          hold_v[2];
  logic [7:0]  hold_d[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no matching expectation", name);
  endtask

  // Reference byte order: first bus byte is most or least significant.
  function automatic logic [15:0] pack(input logic [7:0] b0, input logic [7:0] b1, input bit msb);
    int unsigned w;
    w = msb ? (32'(b0) * 256 + 32'(b1)) : (32'(b1) * 256 + 32'(b0));
    return 16'(w);
  endfunction

  function automatic logic [7:0] beat(input logic [15:0] d, input int i, input bit msb);
    int unsigned sh;
    sh = msb ? 8 * (1 - i) : 8 * i;
    return 8'((32'(d) >> sh) % 256);
  endfunction

  task automatic mon_done(input int k, input logic dn, input logic [15:0] w,
                          input logic [3:0] opc, input logic [11:0] addr, input logic [7:0] by);
    logic [15:0] e;
    if (!dn) return;
    if (k == 0) begin
      if (q_m.size() == 0) begin fail_now("spurious_done_m"); return; end
      e = q_m.pop_front();
    end else begin
      if (q_l.size() == 0) begin fail_now("spurious_done_l"); return; end
      e = q_l.pop_front();
    end
    chk(k == 0 ? "word_m" : "word_l", 32'(w), 32'(e));
    chk(k == 0 ? "opc_m" : "opc_l", 32'(opc), 32'(e / 4096));
    chk(k == 0 ? "addr_m" : "addr_l", 32'(addr), 32'(e % 4096));
    chk(k == 0 ? "byte_m" : "byte_l", 32'(by), 32'(e % 256));
  endtask

  task automatic mon_wr(input int k, input logic wv, input logic wr, input logic [7:0] wd);
    logic [7:0] e;
    if (hold_v[k]) begin
      chk(k == 0 ? "wvalid_hold_m" : "wvalid_hold_l", 32'(wv), 32'(1));
      chk(k == 0 ? "wdata_hold_m" : "wdata_hold_l", 32'(wd), 32'(hold_d[k]));
    end
    if (wv && wr) begin
      if (k == 0) begin
        if (qb_m.size() == 0) begin fail_now("spurious_wbeat_m"); return; end
        e = qb_m.pop_front();
      end else begin
        if (qb_l.size() == 0) begin fail_now("spurious_wbeat_l"); return; end
        e = qb_l.pop_front();
      end
      chk(k == 0 ? "wdata_m" : "wdata_l", 32'(wd), 32'(e));
    end
    hold_v[k] = wv && !wr;
    hold_d[k] = wd;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      mon_done(0, done_m, word_m, opc_m, addr_m, byte_m);
      mon_done(1, done_l, word_l, opc_l, addr_l, byte_l);
      mon_wr(0, if_m.mem_wvalid, wready, if_m.mem_wdata);
      mon_wr(1, if_l.mem_wvalid, wready, if_l.mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit ld, input bit st, input logic [15:0] d);
    ld_start = ld;
    st_start = st;
    st_data  = d;
    tick();
    ld_start = 1'b0;
    st_start = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input int g0, input int g1,
                         input bit with_st);
    last_m = pack(b0, b1, 1'b1);
    last_l = pack(b0, b1, 1'b0);
    q_m.push_back(last_m);
    q_l.push_back(last_l);
    start(1'b1, with_st, 16'($urandom));
    chk("ld_busy", 32'(busy_m), 32'(1));
    chk("ld_rready", 32'(if_m.mem_rready), 32'(1));
    chk("ld_no_wvalid", 32'(if_m.mem_wvalid), 32'(0));
    repeat (g0) begin rdata = 8'($urandom); tick(); end
    rdata = b0; rvalid = 1'b1; tick(); rvalid = 1'b0;
    chk("ld_no_early_done", 32'(done_m), 32'(0));
    repeat (g1) begin rdata = 8'($urandom); tick(); end
    rdata = b1; rvalid = 1'b1; tick(); rvalid = 1'b0;
    chk("ld_done", 32'(done_m), 32'(1));
    chk("ld_idle", 32'(busy_m), 32'(0));
    tick();
    chk("ld_done_pulse", 32'(done_m), 32'(0));
  endtask

  task automatic do_store(input logic [15:0] d, input int w0, input int w1);
    for (int i = 0; i < 2; i++) begin
      qb_m.push_back(beat(d, i, 1'b1));
      qb_l.push_back(beat(d, i, 1'b0));
    end
    q_m.push_back(last_m);
    q_l.push_back(last_l);
    wready = 1'b0;
    start(1'b0, 1'b1, d);
    chk("st_wvalid", 32'(if_m.mem_wvalid), 32'(1));
    chk("st_first_byte", 32'(if_m.mem_wdata), 32'(beat(d, 0, 1'b1)));
    repeat (w0) tick();
    wready = 1'b1; tick(); wready = 1'b0;
    repeat (w1) tick();
    wready = 1'b1; tick(); wready = 1'b0;
    chk("st_done", 32'(done_m), 32'(1));
    chk("st_wvalid_drop", 32'(if_m.mem_wvalid), 32'(0));
    tick();
    chk("st_done_pulse", 32'(done_m), 32'(0));
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_word", 32'(word_m), 32'(0));
    chk("rst_busy", 32'(busy_m), 32'(0));
    chk("rst_done", 32'(done_m), 32'(0));
    chk("rst_rready", 32'(if_m.mem_rready), 32'(0));
    chk("rst_wvalid", 32'(if_l.mem_wvalid), 32'(0));
    rst_n = 1'b1;
    tick();

    do_load(8'hA1, 8'h2B, 0, 0, 1'b0);
    chk("t1_word", 32'(word_m), 32'h0000_A12B);
    chk("t1_opc", 32'(opc_m), 32'h0000_000A);
    chk("t1_addr", 32'(addr_m), 32'h0000_012B);
    chk("t1_byte", 32'(byte_m), 32'h0000_002B);
    chk("t2_word_lsb", 32'(word_l), 32'h0000_2BA1);

    do_store(16'hC3D4, 3, 0);
    chk("t3_word_kept", 32'(word_m), 32'h0000_A12B);

    do_load(8'hA1, 8'h2B, 1, 2, 1'b0);

    // Abort after one byte, then abort colliding with the final beat: neither may complete.
    start(1'b1, 1'b0, 16'h0);
    rdata = 8'h55; rvalid = 1'b1; tick(); rvalid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", 32'(busy_m), 32'(0));
    chk("abort_word", 32'(word_m), 32'(last_m));
    start(1'b1, 1'b0, 16'h0);
    rdata = 8'h66; rvalid = 1'b1; tick();
    rdata = 8'h77; abort = 1'b1; tick(); abort = 1'b0; rvalid = 1'b0;
    chk("abort_prio_idle", 32'(busy_l), 32'(0));
    chk("abort_prio_word", 32'(word_l), 32'(last_l));
    tick();
    do_load(8'h3C, 8'h96, 0, 1, 1'b0);

    do_load(8'hE7, 8'h18, 0, 0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom));
      else
        do_store(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a stalled store drops everything immediately.
    wready = 1'b0;
    start(1'b0, 1'b1, 16'h5A5A);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wvalid", 32'(if_m.mem_wvalid), 32'(0));
    chk("rst_mid_busy", 32'(busy_m), 32'(0));
    chk("rst_mid_word", 32'(word_m), 32'(0));
    tick();
    rst_n = 1'b1;
    last_m = '0;
    last_l = '0;
    tick();

    chk("queues_drained", 32'(q_m.size() + q_l.size() + qb_m.size() + qb_l.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
